// File: rtl/regchk_pkg.sv
// Shared types and defaults for the register-file self-check sequencer.
// Holds the sequencer state encoding, default sizing and a width helper.
package regchk_pkg;

    localparam int REGCHK_WIDTH     = 32;
    localparam int REGCHK_NREGS     = 32;
    localparam int REGCHK_FIRST_REG = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RST  = 3'd1,
        ST_RUN  = 3'd2,
        ST_SCAN = 3'd3,
        ST_DONE = 3'd4
    } regchk_state_e;

    function automatic int regchk_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/regchk_down_counter.sv
// Loadable down-counter shared by the processor reset and run phases.
// Saturates at zero; o_last flags the final counted cycle.
module regchk_down_counter #(
    parameter int CYCW = 16
) (
    input  logic            clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic [CYCW-1:0] i_load_val,
    input  logic            i_dec,
    output logic            o_zero,
    output logic            o_last
);

    logic [CYCW-1:0] r_count;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CYCW'(1);
        end
    end

    assign o_zero = (r_count == '0);
    assign o_last = (r_count == CYCW'(1));

endmodule

// File: rtl/regfile_checker.sv
// Reset/run/scan self-check sequencer for the MIPS core GPR file.
// Optional REGCHK_ERRCOUNT_EN: scan all registers and count mismatches on err_count.
module regfile_checker
    import regchk_pkg::*;
#(
    parameter int WIDTH      = REGCHK_WIDTH,
    parameter int NREGS      = REGCHK_NREGS,
    parameter int FIRST_REG  = REGCHK_FIRST_REG,
    parameter int RST_CYCLES = 1,
    parameter int CYCW       = 16,
    parameter int AW         = regchk_clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CYCW-1:0]  run_cycles,
    output logic             proc_reset,
    output logic             proc_run,
    output logic [AW-1:0]    rf_addr,
    input  logic [WIDTH-1:0] rf_data,
    input  logic [WIDTH-1:0] exp_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [AW-1:0]    fail_idx,
    output logic [WIDTH-1:0] fail_act,
    output logic [WIDTH-1:0] fail_exp
`ifdef REGCHK_ERRCOUNT_EN
    ,
    output logic [AW:0]      err_count
`endif
);

    regchk_state_e    r_state;
    regchk_state_e    w_state_next;
    logic [CYCW-1:0]  r_run_cycles;
    logic [AW-1:0]    r_addr;
    logic             r_pass;
    logic [AW-1:0]    r_fail_idx;
    logic [WIDTH-1:0] r_fail_act;
    logic [WIDTH-1:0] r_fail_exp;

    logic             w_start_ok;
    logic             w_mismatch;
    logic             w_last_reg;
    logic             w_run_zero;
    logic             w_cnt_load;
    logic [CYCW-1:0]  w_cnt_load_val;
    logic             w_cnt_dec;
    logic             w_cnt_zero;
    logic             w_cnt_last;
    logic             w_cnt_done;
    logic             w_enter_scan;
    logic             w_capture;

    assign w_start_ok   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_mismatch   = (rf_data != exp_data);
    assign w_last_reg   = (r_addr == AW'(NREGS - 1));
    assign w_run_zero   = (r_run_cycles == '0);
    // A zero count here is unreachable in normal flow; treating it as expiry prevents a stall.
    assign w_cnt_done   = w_cnt_last || w_cnt_zero;
    assign w_enter_scan = ((r_state == ST_RST) && w_cnt_done && w_run_zero) ||
                          ((r_state == ST_RUN) && w_cnt_done);

    always_comb begin
        w_cnt_load     = 1'b0;
        w_cnt_load_val = '0;
        w_cnt_dec      = 1'b0;
        if (w_start_ok) begin
            w_cnt_load     = 1'b1;
            w_cnt_load_val = CYCW'(RST_CYCLES);
        end else if (r_state == ST_RST) begin
            if (w_cnt_done) begin
                w_cnt_load     = 1'b1;
                w_cnt_load_val = r_run_cycles;
            end else begin
                w_cnt_dec = 1'b1;
            end
        end else if (r_state == ST_RUN) begin
            w_cnt_dec = 1'b1;
        end
    end

    regchk_down_counter #(
        .CYCW (CYCW)
    ) u_cnt (
        .clk        (clk),
        .i_rst      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero),
        .o_last     (w_cnt_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) w_state_next = ST_RST;
            end
            ST_RST: begin
                if (w_cnt_done) w_state_next = w_run_zero ? ST_SCAN : ST_RUN;
            end
            ST_RUN: begin
                if (w_cnt_done) w_state_next = ST_SCAN;
            end
            ST_SCAN: begin
`ifdef REGCHK_ERRCOUNT_EN
                if (w_last_reg) w_state_next = ST_DONE;
`else
                if (w_mismatch || w_last_reg) w_state_next = ST_DONE;
`endif
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        proc_reset = (r_state == ST_IDLE) || (r_state == ST_RST);
        proc_run   = (r_state == ST_RUN);
        busy       = (r_state == ST_RST) || (r_state == ST_RUN) || (r_state == ST_SCAN);
        done       = (r_state == ST_DONE);
    end

`ifdef REGCHK_ERRCOUNT_EN
    logic [AW:0] r_err_count;
    assign w_capture = (r_state == ST_SCAN) && w_mismatch && (r_err_count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_start_ok) begin
            r_err_count <= '0;
        end else if ((r_state == ST_SCAN) && w_mismatch) begin
            r_err_count <= r_err_count + (AW+1)'(1);
        end
    end

    assign err_count = r_err_count;
`else
    assign w_capture = (r_state == ST_SCAN) && w_mismatch;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run_cycles <= '0;
            r_addr       <= '0;
            r_pass       <= 1'b0;
            r_fail_idx   <= '0;
            r_fail_act   <= '0;
            r_fail_exp   <= '0;
        end else if (w_start_ok) begin
            r_run_cycles <= run_cycles;
            r_pass       <= 1'b0;
            r_fail_idx   <= '0;
            r_fail_act   <= '0;
            r_fail_exp   <= '0;
        end else if (w_enter_scan) begin
            r_addr <= AW'(FIRST_REG);
        end else if (r_state == ST_SCAN) begin
            if (w_capture) begin
                r_fail_idx <= r_addr;
                r_fail_act <= rf_data;
                r_fail_exp <= exp_data;
            end
`ifdef REGCHK_ERRCOUNT_EN
            if (w_last_reg) begin
                r_pass <= (r_err_count == '0) && !w_mismatch;
            end else begin
                r_addr <= r_addr + AW'(1);
            end
`else
            // Early exit leaves rf_addr on the failing register.
            if (w_mismatch) begin
                r_pass <= 1'b0;
            end else if (w_last_reg) begin
                r_pass <= 1'b1;
            end else begin
                r_addr <= r_addr + AW'(1);
            end
`endif
        end
    end

    assign rf_addr  = r_addr;
    assign pass     = r_pass;
    assign fail_idx = r_fail_idx;
    assign fail_act = r_fail_act;
    assign fail_exp = r_fail_exp;

endmodule

// File: tb/tb_regfile_checker.sv
// Randomised self-checking bench for regfile_checker against a behavioural scan model.
// Also builds with REGCHK_ERRCOUNT_EN to cover the mismatch-counting variant.
module tb_regfile_checker;

    localparam int WIDTH = 32;
    localparam int NR    = 32;
    localparam int FIRST = 1;
    localparam int RSTC  = 1;
    localparam int CYCW  = 16;
    localparam int AW    = 5;

    logic             clk;
    logic             reset;
    logic             start;
    logic [CYCW-1:0]  run_cycles;
    logic             proc_reset;
    logic             proc_run;
    logic [AW-1:0]    rf_addr;
    logic [WIDTH-1:0] rf_data;
    logic [WIDTH-1:0] exp_data;
    logic             busy;
    logic             done;
    logic             pass;
    logic [AW-1:0]    fail_idx;
    logic [WIDTH-1:0] fail_act;
    logic [WIDTH-1:0] fail_exp;
`ifdef REGCHK_ERRCOUNT_EN
    logic [AW:0]      err_count;
`endif

    logic [WIDTH-1:0] gpr  [NR];
    logic [WIDTH-1:0] expv [NR];

    int n_cmp;
    int n_mis;
    int n_run;

    assign rf_data  = gpr[rf_addr];
    assign exp_data = expv[rf_addr];

    regfile_checker #(
        .WIDTH      (WIDTH),
        .NREGS      (NR),
        .FIRST_REG  (FIRST),
        .RST_CYCLES (RSTC),
        .CYCW       (CYCW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .run_cycles (run_cycles),
        .proc_reset (proc_reset),
        .proc_run   (proc_run),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .exp_data   (exp_data),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_idx   (fail_idx),
        .fail_act   (fail_act),
        .fail_exp   (fail_exp)
`ifdef REGCHK_ERRCOUNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic fill_equal(input logic [WIDTH-1:0] v);
        for (int i = 0; i < NR; i++) begin
            gpr[i]  = v;
            expv[i] = v;
        end
    endtask

    task automatic fill_random(input int nbad);
        int idx;
        for (int i = 0; i < NR; i++) begin
            gpr[i]  = $urandom;
            expv[i] = gpr[i];
        end
        for (int k = 0; k < nbad; k++) begin
            idx = $urandom_range(0, NR - 1);
            expv[idx] = gpr[idx] ^ (32'h1 << $urandom_range(0, 31));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_proc_reset"}, proc_reset, 1);
        chk({tag, "_proc_run"},   proc_run,   0);
        chk({tag, "_busy"},       busy,       0);
        chk({tag, "_done"},       done,       0);
        chk({tag, "_pass"},       pass,       0);
        chk({tag, "_rf_addr"},    rf_addr,    0);
        chk({tag, "_fail_idx"},   fail_idx,   0);
        chk({tag, "_fail_act"},   fail_act,   0);
        chk({tag, "_fail_exp"},   fail_exp,   0);
`ifdef REGCHK_ERRCOUNT_EN
        chk({tag, "_err_count"},  err_count,  0);
`endif
    endtask

    // Model: scan FIRST..NR-1, find first mismatch and total mismatch count.
    task automatic run_seq(input int rc, input bit poke);
        int  fi;
        int  nerr;
        int  exp_n;
        int  exp_max;
        int  n;
        int  runs;
        int  maxa;
        bit  got;
        fi   = -1;
        nerr = 0;
        for (int i = FIRST; i < NR; i++) begin
            if (gpr[i] !== expv[i]) begin
                nerr++;
                if (fi < 0) fi = i;
            end
        end
`ifdef REGCHK_ERRCOUNT_EN
        exp_n   = RSTC + rc + (NR - FIRST);
        exp_max = NR - 1;
`else
        exp_n   = RSTC + rc + ((fi >= 0) ? (fi - FIRST + 1) : (NR - FIRST));
        exp_max = (fi >= 0) ? fi : NR - 1;
`endif
        @(negedge clk);
        run_cycles = CYCW'(rc);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_done_drop", done, 0);
        chk("start_busy", busy, 1);
        chk("start_pass_clr", pass, 0);
        chk("start_fidx_clr", fail_idx, 0);
        chk("start_fact_clr", fail_act, 0);
        chk("start_fexp_clr", fail_exp, 0);
        n = 0; runs = 0; maxa = 0; got = 1'b0;
        while (!got && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (proc_run) runs++;
            if (busy && !proc_run && !proc_reset && (int'(rf_addr) > maxa)) maxa = int'(rf_addr);
            if (done) got = 1'b1;
            if (poke && n == 2) begin
                start      = 1'b1;
                run_cycles = CYCW'(rc + 7);
            end else if (poke && n == 3) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("done_seen", got, 1);
        chk("done_edge", n, exp_n);
        chk("pass", pass, (nerr == 0));
        chk("run_cycles_seen", runs, rc);
        chk("max_scan_addr", maxa, exp_max);
        chk("fail_idx", fail_idx, (fi >= 0) ? fi : 0);
        chk("fail_act", fail_act, (fi >= 0) ? gpr[fi] : 0);
        chk("fail_exp", fail_exp, (fi >= 0) ? expv[fi] : 0);
        chk("proc_frozen", {proc_reset, proc_run}, 2'b00);
`ifdef REGCHK_ERRCOUNT_EN
        chk("err_count", err_count, nerr);
`endif
        n_run++;
        $display("run %0d: rc=%0d poke=%0d done_edge=%0d/%0d pass=%0d fail_idx=%0d mism_model=%0d",
                 n_run, rc, poke, n, exp_n, pass, fail_idx, nerr);
    endtask

    initial begin
        n_cmp = 0; n_mis = 0; n_run = 0;
        reset = 1'b1; start = 1'b0; run_cycles = '0;
        fill_equal(32'hcafebabe);
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        @(negedge clk);
        reset = 1'b0;

        // All registers match, run budget 5: done on edge 37
        run_seq(5, 1'b0);

        // Single mismatch at r5, restarted from DONE
        gpr[5] = 32'h1; expv[5] = 32'h2;
        run_seq(5, 1'b0);

        // Zero budget, r0 differs but must be skipped
        fill_equal(32'h12345678);
        gpr[0] = 32'h0;
        run_seq(0, 1'b0);

        // start pulse while busy is ignored
        run_seq(5, 1'b1);

        // Mismatch only at the last register
        fill_equal(32'h0f0f0f0f);
        expv[NR-1] = 32'hf0f0f0f0;
        run_seq(3, 1'b0);

        // Mismatches at r3, r9, r31
        fill_equal(32'h55aa55aa);
        expv[3] = 32'h0; expv[9] = 32'h1; expv[31] = 32'h2;
        run_seq(4, 1'b0);

        // Reset in the middle of SCAN aborts to reset values
        fill_equal(32'h0);
        @(negedge clk);
        run_cycles = CYCW'(3);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_scan_busy", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("abort");
        @(negedge clk);
        reset = 1'b0;

        for (int t = 0; t < 10; t++) begin
            fill_random($urandom_range(0, 3));
            run_seq($urandom_range(0, 20), t[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/regfile_checker.md
Name: regfile_checker

Overview:
- Synthesizable self-check sequencer for the MIPS core, and parametrised successor to the bench-only reset/run/compare flow.
- Holds the processor in reset, releases it for a programmable number of cycles, then freezes it.
- Scans the GPR contents through a read port and compares each against an expected-value port.
- Reports pass/fail with first-failure details, so the same check runs in simulation and on FPGA.

Parameters:
- WIDTH, 32: GPR data width.
- NREGS, 32: number of GPRs; AW = clog2(NREGS).
- FIRST_REG, 1: first register index scanned (r0 is skipped). Must be < NREGS.
- RST_CYCLES, 1: cycles proc_reset stays high after start. Must be >= 1.
- CYCW, 16: width of run_cycles.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- start, in, 1: single-cycle request; sampled in IDLE or DONE only.
- run_cycles, in, CYCW: processor run budget; sampled with start.
- proc_reset, out, 1: reset to the processor.
- proc_run, out, 1: clock enable to the processor; high only in RUN.
- rf_addr, out, AW: GPR / expected-value read index.
- rf_data, in, WIDTH: GPR contents at rf_addr (combinational read).
- exp_data, in, WIDTH: expected value at rf_addr (combinational read).
- busy, out, 1: high in RST, RUN and SCAN.
- done, out, 1: high in DONE.
- pass, out, 1: valid while done is high.
- fail_idx, out, AW: index of the first mismatch.
- fail_act, out, WIDTH: actual value at the first mismatch.
- fail_exp, out, WIDTH: expected value at the first mismatch.

Behaviour:
- Reset values, applied asynchronously on reset: state=IDLE, proc_reset=1, proc_run=0, rf_addr=0, busy=0, done=0, pass=0, fail_idx=0, fail_act=0, fail_exp=0, all counters 0.
- States: IDLE, RST, RUN, SCAN, DONE.
- IDLE / DONE:
  - proc_reset=1 in IDLE. In DONE, proc_reset=0 and proc_run=0, so the processor is frozen and its state preserved.
  - start=1 latches run_cycles, loads the counter with RST_CYCLES, clears pass and fail_*, and moves to RST.
- RST: proc_reset=1, proc_run=0. Counter decrements each cycle; at 1 the block moves to RUN, or straight to SCAN if the latched run_cycles is 0.
- RUN: proc_reset=0, proc_run=1 for exactly run_cycles cycles, then SCAN with rf_addr=FIRST_REG.
- SCAN:
  - proc_run=0. One register per cycle.
  - Each cycle compares rf_data with exp_data (full WIDTH, unsigned equality).
  - On mismatch: fail_idx, fail_act and fail_exp are captured from the current rf_addr/data, pass=0, move to DONE.
  - If the last register (NREGS-1) matches: pass=1, move to DONE.
  - rf_addr increments; it never wraps past NREGS-1.
- Latency on an all-pass run: done rises on the Nth rising edge after the edge that sampled start, where N = RST_CYCLES + run_cycles + (NREGS - FIRST_REG). Defaults with run_cycles=5 give N=37.
- start while busy is ignored, with no effect on state or the latched budget.
- start in DONE restarts the sequence. done drops on the same edge.
- reset asserted mid-operation aborts immediately to the reset values. The processor is held in reset (proc_reset=1).
- busy, done and proc_* are decoded from registered state only (glitch-free).

Optional Feature:
- Macro: REGCHK_ERRCOUNT_EN.
- With the macro defined:
  - A mismatch does not end SCAN; all registers FIRST_REG..NREGS-1 are always scanned.
  - An extra output port err_count (AW+1 bits, reset 0, cleared on start) counts mismatches.
  - fail_* still hold the FIRST mismatch only.
  - pass = (err_count == 0) at DONE.
  - Latency is always the full N above.
- Without the macro: early exit on first mismatch as described, and no err_count port.

Decomposition:
- Shared package regchk_pkg:
  - State encoding typedef (IDLE, RST, RUN, SCAN, DONE).
  - Default constants WIDTH=32, NREGS=32, FIRST_REG=1.
  - A clog2 helper function.
- One natural sub-module: regchk_down_counter, a loadable CYCW-bit down-counter with a zero flag. It is shared by the RST and RUN phases.
- Compare and capture logic stay in the top.

Test Plan:
- Expected equals actual (all 0xcafebabe), run_cycles=5 → done on edge 37, pass=1, exactly 5 proc_run cycles.
- r5 = 0x00000001 vs expected 0x00000002 → done, pass=0, fail_idx=5, fail_act=0x00000001, fail_exp=0x00000002; no addresses beyond 5 scanned.
- run_cycles=0 → no proc_run pulse; SCAN starts right after RST; done on edge 32.
- start pulsed during RUN → ignored, same done timing. reset asserted mid-SCAN → all outputs at reset values, proc_reset=1.
- Start again from DONE with new data → pass and fail_* cleared, new result reported.
- REGCHK_ERRCOUNT_EN with mismatches at r3, r9, r31 → err_count=3, fail_idx=3, pass=0, done on edge N.
